// File: rtl/raycast_frame_scheduler.sv
// Walks the slice calculator across every column of a frame and writes each slice into the column buffer.
// Each column costs BEGIN + k WAIT + WRITE cycles; end_calc is awaited, and the watchdog bounds the wait.
module raycast_frame_scheduler #(
  parameter int NUM_COLS = 160,
  parameter int TIMEOUT  = 4095,
  parameter int TO_W     = 12
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               frame_req,
  input  logic signed [12:0] playerX_in,
  input  logic signed [12:0] playerY_in,
  input  logic signed [9:0]  angle_X_in,
  input  logic signed [9:0]  angle_Y_in,
  output logic signed [12:0] playerX,
  output logic signed [12:0] playerY,
  output logic signed [9:0]  angle_X,
  output logic signed [9:0]  angle_Y,
  output logic [7:0]         column_count,
  output logic               begin_calc,
  input  logic               end_calc,
  input  logic [6:0]         slice_size,
  output logic               wr_en,
  output logic [7:0]         wr_addr,
  output logic [6:0]         wr_data,
  output logic               frame_busy,
  output logic               frame_done,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_BEGIN,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [7:0]      LAST_COL = 8'(NUM_COLS - 1);
  localparam logic [TO_W-1:0] WD_LAST  = TO_W'(TIMEOUT - 1);

  state_t          state_q;
  state_t          state_d;
  logic [TO_W-1:0] watchdog;
  logic [6:0]      slice_reg;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    begin_calc = 1'b0;
    wr_en      = 1'b0;
    frame_done = 1'b0;
    frame_busy = 1'b1;
    case (state_q)
      S_IDLE: begin
        frame_busy = 1'b0;
        if (frame_req) state_d = S_LATCH;
      end
      S_LATCH: state_d = S_BEGIN;
      S_BEGIN: begin
        begin_calc = 1'b1;
        state_d    = S_WAIT;
      end
      // A result arriving on the watchdog's last cycle still counts as a real answer.
      S_WAIT: begin
        if (end_calc || (watchdog == WD_LAST)) state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        state_d = (column_count == LAST_COL) ? S_DONE : S_BEGIN;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      playerX      <= '0;
      playerY      <= '0;
      angle_X      <= '0;
      angle_Y      <= '0;
      column_count <= '0;
      watchdog     <= '0;
      slice_reg    <= '0;
      timeout_err  <= 1'b0;
    end else begin
      case (state_q)
        S_LATCH: begin
          playerX      <= playerX_in;
          playerY      <= playerY_in;
          angle_X      <= angle_X_in;
          angle_Y      <= angle_Y_in;
          column_count <= '0;
          timeout_err  <= 1'b0;
        end
        S_BEGIN: watchdog <= '0;
        S_WAIT: begin
          if (end_calc) begin
            slice_reg <= slice_size;
          end else if (watchdog == WD_LAST) begin
            slice_reg   <= '0;
            timeout_err <= 1'b1;
          end else begin
            watchdog <= watchdog + TO_W'(1);
          end
        end
        S_WRITE: begin
          if (column_count != LAST_COL) column_count <= column_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign wr_addr = column_count;
  assign wr_data = slice_reg;

endmodule

// File: tb/tb_raycast_frame_scheduler.sv
// Frame-level bench: a calculator model answers begin_calc, a monitor logs every buffer write,
// and a table of frame scenarios is replayed and checked against hand-computed expectations.
`timescale 1ns/1ps
module tb_raycast_frame_scheduler;

  localparam int NUM_COLS = 160;
  localparam int TIMEOUT  = 16;
  localparam int NONE     = 255;

  logic               clock = 1'b0;
  logic               resetn;
  logic               frame_req;
  logic signed [12:0] playerX_in, playerY_in;
  logic signed [9:0]  angle_X_in, angle_Y_in;
  logic signed [12:0] playerX, playerY;
  logic signed [9:0]  angle_X, angle_Y;
  logic [7:0]         column_count;
  logic               begin_calc;
  logic               end_calc = 1'b0;
  logic [6:0]         slice_size = 7'd0;
  logic               wr_en;
  logic [7:0]         wr_addr;
  logic [6:0]         wr_data;
  logic               frame_busy, frame_done, timeout_err;

  raycast_frame_scheduler #(.NUM_COLS(NUM_COLS), .TIMEOUT(TIMEOUT), .TO_W(12)) dut (
    .clock(clock), .resetn(resetn), .frame_req(frame_req),
    .playerX_in(playerX_in), .playerY_in(playerY_in),
    .angle_X_in(angle_X_in), .angle_Y_in(angle_Y_in),
    .playerX(playerX), .playerY(playerY), .angle_X(angle_X), .angle_Y(angle_Y),
    .column_count(column_count), .begin_calc(begin_calc),
    .end_calc(end_calc), .slice_size(slice_size),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_busy(frame_busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #10 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  logic all_or;
  assign all_or = |{playerX, playerY, angle_X, angle_Y, column_count, begin_calc,
                    wr_en, wr_addr, wr_data, frame_busy, frame_done, timeout_err};

  // Calculator model: answers 5 cycles after begin_calc (16 on the tie column), never on no_ans.
  int cur_no_ans = NONE, cur_tie = NONE, cur_spur = NONE;
  int m_cnt = 0, m_col = 0;
  always @(negedge clock) begin
    end_calc = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && m_col != cur_no_ans) begin
        end_calc   = 1'b1;
        slice_size = (m_col == cur_tie) ? 7'd42 : 7'(m_col % 128);
      end
    end
    if (begin_calc) begin
      m_col = int'(column_count);
      m_cnt = (m_col == cur_tie) ? 16 : 5;
      if (m_col == cur_spur) begin
        end_calc   = 1'b1;
        slice_size = 7'd99;
      end
    end
  end

  typedef struct {
    int addr; int data; int err; int gap; bit pose_ok;
  } wr_t;
  wr_t wq[$];
  int  done_cnt = 0, done_cyc = 0;
  int  bcyc[256];
  logic signed [12:0] exp_px, exp_py;
  logic signed [9:0]  exp_ax, exp_ay;

  always @(negedge clock) begin
    wr_t w;
    if (begin_calc) bcyc[column_count] = cyc;
    if (wr_en) begin
      w.addr    = int'(wr_addr);
      w.data    = int'(wr_data);
      w.err     = int'(timeout_err);
      w.gap     = cyc - bcyc[wr_addr];
      w.pose_ok = (playerX == exp_px) && (playerY == exp_py) &&
                  (angle_X == exp_ax) && (angle_Y == exp_ay);
      wq.push_back(w);
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  typedef struct {
    logic signed [12:0] px, py;
    logic signed [9:0]  ax, ay;
    int no_ans, tie, spur;
    bit disturb;
    int exp_len;
    int exp_err;
  } scen_t;
  scen_t scen[4];

  task automatic start_frame(input logic signed [12:0] px, input logic signed [12:0] py,
                             input logic signed [9:0] ax, input logic signed [9:0] ay,
                             output int start);
    exp_px = px; exp_py = py; exp_ax = ax; exp_ay = ay;
    wq.delete();
    done_cnt = 0;
    @(negedge clock);
    playerX_in = px; playerY_in = py; angle_X_in = ax; angle_Y_in = ay;
    frame_req = 1'b1;
    @(negedge clock);
    frame_req = 1'b0;
    start = cyc;
  endtask

  task automatic run_frame(input int s);
    scen_t v;
    int start, t, exp_data, exp_gap, exp_err;
    v = scen[s];
    cur_no_ans = v.no_ans; cur_tie = v.tie; cur_spur = v.spur;
    start_frame(v.px, v.py, v.ax, v.ay, start);
    check("busy_in_latch", frame_busy, 1);
    @(negedge clock);
    check("err_cleared_at_latch", timeout_err, 0);
    check("pose_x_latched", playerX, v.px);
    check("pose_y_latched", playerY, v.py);
    check("ang_x_latched", angle_X, v.ax);
    check("ang_y_latched", angle_Y, v.ay);
    if (v.disturb) begin
      repeat (500) @(negedge clock);
      playerX_in = '0; playerY_in = '0; angle_X_in = '0; angle_Y_in = '0;
      frame_req = 1'b1;
      @(negedge clock);
      frame_req = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    check("frame_done_seen", done_cnt, 1);
    check("frame_len", done_cyc - start + 1, v.exp_len);
    check("pose_x_at_done", playerX, v.px);
    check("ang_y_at_done", angle_Y, v.ay);
    check("timeout_err_at_done", timeout_err, v.exp_err);
    repeat (20) @(negedge clock);
    check("idle_after_frame", frame_busy, 0);
    check("single_done", done_cnt, 1);
    check("write_count", wq.size(), NUM_COLS);
    for (int i = 0; i < wq.size(); i++) begin
      exp_data = (i == v.no_ans) ? 0 : (i == v.tie) ? 42 : i % 128;
      exp_gap  = (i == v.no_ans || i == v.tie) ? TIMEOUT + 1 : 6;
      exp_err  = (i >= v.no_ans) ? 1 : 0;
      check($sformatf("wr_addr[%0d]", i), wq[i].addr, i);
      check($sformatf("wr_data[%0d]", i), wq[i].data, exp_data);
      check($sformatf("wr_gap[%0d]", i), wq[i].gap, exp_gap);
      check($sformatf("wr_err[%0d]", i), wq[i].err, exp_err);
      check($sformatf("wr_pose[%0d]", i), wq[i].pose_ok, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int start, t, n_wr, n_done;
    scen[0] = '{13'sd100, -13'sd50, 10'sd3, 10'sd128, NONE, NONE, NONE, 1'b1, 1122, 0};
    scen[1] = '{13'sd7, 13'sd8, -10'sd1, -10'sd2, 7, NONE, NONE, 1'b0, 1133, 1};
    scen[2] = '{-13'sd4095, 13'sd4095, 10'sd511, -10'sd512, NONE, 20, 30, 1'b0, 1133, 0};
    scen[3] = '{-13'sd100, 13'sd50, -10'sd3, 10'sd5, NONE, NONE, NONE, 1'b0, 1122, 0};

    resetn = 1'b0; frame_req = 1'b0;
    playerX_in = '0; playerY_in = '0; angle_X_in = '0; angle_Y_in = '0;
    exp_px = '0; exp_py = '0; exp_ax = '0; exp_ay = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check($sformatf("idle_outputs_zero[%0d]", i), all_or, 0);
    end

    for (int s = 0; s < 3; s++) run_frame(s);

    // Reset during column 50 abandons the frame.
    cur_no_ans = NONE; cur_tie = NONE; cur_spur = NONE;
    start_frame(13'sd11, 13'sd22, 10'sd33, 10'sd44, start);
    t = 0;
    while (wq.size() < 50 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    check("reached_col_50", column_count, 50);
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("rst_outputs_zero", all_or, 0);
    check("rst_pose_zero", playerX, 0);
    check("rst_busy_low", frame_busy, 0);
    n_wr = wq.size();
    n_done = done_cnt;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    check("no_writes_after_rst", wq.size(), n_wr);
    check("no_done_after_rst", done_cnt, n_done);
    check("idle_after_rst", all_or, 0);

    run_frame(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/raycast_frame_scheduler.md
Name: raycast_frame_scheduler

Overview:
Sequences the slice-size calculator across every screen column of one frame. On a frame request it snapshots the player pose and drives the calculator with a stable pose and column index. For each column it issues a begin_calc pulse, waits for end_calc and writes the resulting slice size into the column buffer that the wall drawer reads. A watchdog prevents a hung calculation from stalling the frame.

Parameters:
NUM_COLS, 160, number of screen columns per frame; column_count runs 0..NUM_COLS-1.
TIMEOUT, 4095, maximum cycles spent waiting for end_calc on one column.
TO_W, 12, watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
clock  input  1  system clock, 50 MHz
resetn  input  1  synchronous active-low reset
frame_req  input  1  request to render one frame; sampled only in S_IDLE
playerX_in, playerY_in  input  13 each, signed  live player position
angle_X_in, angle_Y_in  input  10 each, signed  live player angle (integer part and fraction part)
playerX, playerY  output  13 each, signed  snapshotted position, to the calculator
angle_X, angle_Y  output  10 each, signed  snapshotted angle, to the calculator
column_count  output  8  current column, to the calculator
begin_calc  output  1  one-cycle start pulse to the calculator
end_calc  input  1  calculator done; sampled only in S_WAIT
slice_size  input  7  calculator result, valid in the cycle end_calc=1
wr_en  output  1  column buffer write strobe
wr_addr  output  8  column buffer address (equals column_count)
wr_data  output  7  slice size written to the buffer
frame_busy  output  1  high in every state except S_IDLE
frame_done  output  1  one-cycle pulse when the frame is finished
timeout_err  output  1  sticky; set when any column in the current frame times out

Behaviour:
- Reset (resetn=0 at a posedge): state is S_IDLE.
  - Every output register resets to 0: pose, column_count, watchdog, slice_reg, timeout_err.
  - All strobes are low.
  - Reset applied mid-frame abandons the frame: no frame_done, no further writes.
- Strobes are Moore decodes of the state:
  - begin_calc is high only in S_BEGIN.
  - wr_en is high only in S_WRITE.
  - frame_done is high only in S_DONE.
- wr_addr = column_count and wr_data = slice_reg at all times.
- State machine:
  - S_IDLE: go to S_LATCH if frame_req=1, otherwise stay.
  - S_LATCH (1 cycle):
    - Capture the four pose inputs into the pose registers.
    - column_count <= 0; timeout_err <= 0.
    - Go to S_BEGIN.
  - S_BEGIN (1 cycle): begin_calc=1; watchdog <= 0; go to S_WAIT.
  - S_WAIT, checked in this order each cycle:
    - If end_calc=1: slice_reg <= slice_size; go to S_WRITE.
    - Else if watchdog == TIMEOUT-1: slice_reg <= 0; timeout_err <= 1; go to S_WRITE.
    - Else: watchdog increments; stay in S_WAIT.
    - If end_calc and the timeout condition occur in the same cycle, end_calc wins and the real slice is written.
  - S_WRITE (1 cycle): wr_en=1.
    - If column_count == NUM_COLS-1, go to S_DONE.
    - Otherwise column_count <= column_count+1 and go to S_BEGIN.
  - S_DONE (1 cycle): frame_done=1; go to S_IDLE.
- Pose outputs hold from S_LATCH until the next S_LATCH. Input changes during a frame have no effect.
- frame_req is ignored while frame_busy=1; requests are not queued.
  - If frame_req is held high continuously, the next frame starts after exactly one S_IDLE cycle.
- end_calc asserted outside S_WAIT is ignored.
- Per-column cost: 1 (S_BEGIN) + k + 1 (S_WRITE) cycles, where k is the number of S_WAIT cycles, including the cycle that sees end_calc (k ≥ 1).
- Frame cost: 1 (S_LATCH) + Σ(k+2) over all columns + 1 (S_DONE), measured from leaving S_IDLE.
- A timeout occurs after exactly TIMEOUT S_WAIT cycles.
- column_count never exceeds NUM_COLS-1; there is no wrap-around within a frame.
- No arithmetic beyond the increments above; all counters are unsigned.

Test Plan:
- Reset then idle: after resetn is deasserted with frame_req=0, hold for 20 cycles. All outputs must stay 0, including frame_busy, wr_en and begin_calc.
- Full frame: pulse frame_req with playerX_in=100, playerY_in=-50, angle_X_in=3, angle_Y_in=128. The calculator model answers end_calc 5 cycles after each begin_calc with slice_size = column mod 128.
  - Require exactly 160 writes, addr 0..159, data = addr mod 128.
  - Require one frame_done pulse, 1 + 160×7 + 1 = 1122 cycles after leaving S_IDLE.
  - Require pose outputs to read 100/-50/3/128 throughout.
- Pose stability: change all pose inputs to 0 in the middle of that frame. The pose outputs must stay unchanged until frame_done.
- Timeout: with TIMEOUT=16, the model never answers column 7.
  - Require wr_data=0 at addr 7, written 16 S_WAIT cycles after its begin_calc.
  - Require timeout_err=1 from then on, the remaining columns written normally, and timeout_err cleared at the next S_LATCH.
- Tie and ignore:
  - end_calc with slice_size=42 on the same cycle the watchdog hits TIMEOUT-1 must write 42.
  - end_calc pulsed during S_BEGIN must be ignored.
  - frame_req pulsed mid-frame must not start an extra frame.
- Reset mid-frame: assert resetn=0 during column 50.
  - From the next cycle require all outputs 0, no frame_done, and no further wr_en.
  - After release and a new frame_req, require writes to restart at addr 0.
